axi_decerr_slave: RTL and testbench

//  Terminal AXI slave that answers any transaction with DECERR. One instance hangs off a spare

---
 rtl/axi_decerr_slave_pkg.sv | 11 +
 rtl/axi_decerr_slave_if.sv | 37 +++
 rtl/axi_decerr_slave.sv | 77 +++++++
 tb/tb_axi_decerr_slave.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/axi_decerr_slave_pkg.sv
// axi_decerr_slave_pkg: AXI response codes and burst-field types shared by the DECERR slave.
package axi_decerr_slave_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;
  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
endpackage

// File: rtl/axi_decerr_slave_if.sv
// axi_decerr_slave_if: AXI channel bundle seen by a terminal slave.
interface axi_decerr_slave_if
  import axi_decerr_slave_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                    aw_valid, aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  len_t                    aw_len;
  logic                    w_valid, w_ready, w_last;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid, b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  resp_t                   b_resp;
  logic                    ar_valid, ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  len_t                    ar_len;
  logic                    r_valid, r_ready, r_last;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;
  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );
  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );
endinterface

// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: terminal AXI slave that answers every read and write burst with DECERR.
module axi_decerr_slave
  import axi_decerr_slave_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0
) (
  input logic clk,
  input logic rst,
  axi_decerr_slave_if.slave m
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_st, w_nxt;
  r_state_t r_st, r_nxt;
  logic [ID_WIDTH-1:0] bid, rid;
  len_t rlen, rcnt;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] unused_addr;
  logic unused_bits;
  assign unused_addr = m.aw_addr | m.ar_addr;
  assign unused_bits = ^{m.w_data, m.w_strb, m.aw_len};
  assign m.b_id   = bid;
  assign m.b_resp = RESP_DECERR;
  assign m.r_id   = rid;
  assign m.r_resp = RESP_DECERR;
  assign m.r_data = RDATA_FILL;
  assign m.r_last = rcnt == rlen;
  always_comb begin
    aw_hs = m.aw_valid && m.aw_ready;
    w_hs  = m.w_valid && m.w_ready;
    b_hs  = m.b_valid && m.b_ready;
    ar_hs = m.ar_valid && m.ar_ready;
    r_hs  = m.r_valid && m.r_ready;
    w_nxt = w_st == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
            w_st == W_DATA ? (w_hs && m.w_last ? W_RESP : W_DATA) :
            w_st == W_RESP ? (b_hs ? W_IDLE : W_RESP) : W_IDLE;
    r_nxt = r_st == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_hs && m.r_last ? R_IDLE : R_DATA);
  end
  // Handshake outputs are decoded from the next state so they stay registered yet track the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_st       <= W_IDLE;
      m.aw_ready <= 1'b0;
      m.w_ready  <= 1'b0;
      m.b_valid  <= 1'b0;
      bid        <= '0;
    end else begin
      w_st       <= w_nxt;
      m.aw_ready <= w_nxt == W_IDLE;
      m.w_ready  <= w_nxt == W_DATA;
      m.b_valid  <= w_nxt == W_RESP;
      if (aw_hs) bid <= m.aw_id;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= R_IDLE;
      m.ar_ready <= 1'b0;
      m.r_valid  <= 1'b0;
      rid        <= '0;
      rlen       <= '0;
      rcnt       <= '0;
    end else begin
      r_st       <= r_nxt;
      m.ar_ready <= r_nxt == R_IDLE;
      m.r_valid  <= r_nxt == R_DATA;
      rcnt       <= ar_hs ? '0 : r_hs ? rcnt + 8'd1 : rcnt;
      if (ar_hs) begin
        rid  <= m.ar_id;
        rlen <= m.ar_len;
      end
    end
  end
endmodule

// File: tb/tb_axi_decerr_slave.sv
// tb_axi_decerr_slave: transaction-level model checked every cycle plus directed literal checks.
module tb_axi_decerr_slave;
  import axi_decerr_slave_pkg::*;
  localparam logic [63:0] FILL = 64'hDEAD_BEEF_0BAD_F00D;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  axi_decerr_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();
  axi_decerr_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .RDATA_FILL(FILL)) dut (
    .clk(clk), .rst(rst), .m(bus)
  );
  always #5 clk = ~clk;
  // Model: in_rst, write outstanding/awaiting B, read beats remaining.
  logic mr = 1, wb = 0, bp = 0, rb = 0;
  logic [3:0] wid_m = 0, rid_m = 0;
  int rleft = 0;
  logic e_awr, e_wr, e_bv, e_arr, e_rv, awh, wh, bh, arh, rh;
  assign e_awr = !mr && !wb && !bp;
  assign e_wr  = !mr && wb;
  assign e_bv  = !mr && bp;
  assign e_arr = !mr && !rb;
  assign e_rv  = !mr && rb;
  assign awh = bus.aw_valid && e_awr;
  assign wh  = bus.w_valid && e_wr;
  assign bh  = bus.b_ready && e_bv;
  assign arh = bus.ar_valid && e_arr;
  assign rh  = bus.r_ready && e_rv;
  always @(posedge clk) begin
    if (rst) begin
      mr <= 1; wb <= 0; bp <= 0; rb <= 0; rleft <= 0;
    end else begin
      mr <= 0;
      if (awh) begin wb <= 1; wid_m <= bus.aw_id; end
      if (wh && bus.w_last) begin wb <= 0; bp <= 1; end
      if (bh) bp <= 0;
      if (arh) begin rb <= 1; rid_m <= bus.ar_id; rleft <= int'(bus.ar_len) + 1; end
      if (rh) begin rleft <= rleft - 1; if (rleft == 1) rb <= 0; end
    end
  end
  int beats = 0, last_at = 0;
  logic [3:0] last_rid = 0;
  always @(posedge clk) begin
    if (bus.r_valid && bus.r_ready) begin
      beats <= beats + 1;
      last_rid <= bus.r_id;
      if (bus.r_last) last_at <= beats + 1;
    end
  end
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("aw_ready", 64'(bus.aw_ready), 64'(e_awr));
    chk("w_ready", 64'(bus.w_ready), 64'(e_wr));
    chk("b_valid", 64'(bus.b_valid), 64'(e_bv));
    chk("ar_ready", 64'(bus.ar_ready), 64'(e_arr));
    chk("r_valid", 64'(bus.r_valid), 64'(e_rv));
    if (e_bv) begin
      chk("b_id", 64'(bus.b_id), 64'(wid_m));
      chk("b_resp", 64'(bus.b_resp), 64'(2'b11));
    end
    if (e_rv) begin
      chk("r_id", 64'(bus.r_id), 64'(rid_m));
      chk("r_last", 64'(bus.r_last), 64'(rleft == 1));
      chk("r_data", bus.r_data, FILL);
      chk("r_resp", 64'(bus.r_resp), 64'(2'b11));
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int b0;
    {bus.aw_valid, bus.w_valid, bus.w_last, bus.b_ready, bus.ar_valid, bus.r_ready} = '0;
    bus.aw_id = 0; bus.aw_addr = 32'h1000; bus.aw_len = 0;
    bus.ar_id = 0; bus.ar_addr = 32'h2000; bus.ar_len = 0;
    bus.w_data = 64'h1234; bus.w_strb = 8'hFF;
    repeat (3) tick;
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    rst = 0;
    tick;
    chk("post_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
    chk("post_rst_ar_ready", 64'(bus.ar_ready), 64'd1);
    // single-beat write
    bus.aw_valid = 1; bus.aw_id = 3; bus.aw_len = 0;
    tick;
    bus.aw_valid = 0; bus.w_valid = 1; bus.w_last = 1;
    chk("t1_w_ready", 64'(bus.w_ready), 64'd1);
    tick;
    bus.w_valid = 0;
    chk("t1_b_valid", 64'(bus.b_valid), 64'd1);
    chk("t1_b_id", 64'(bus.b_id), 64'd3);
    chk("t1_b_resp", 64'(bus.b_resp), 64'd3);
    bus.b_ready = 1;
    tick;
    bus.b_ready = 0;
    chk("t1_b_clear", 64'(bus.b_valid), 64'd0);
    // four-beat read, no backpressure
    b0 = beats;
    bus.ar_valid = 1; bus.ar_id = 5; bus.ar_len = 3; bus.r_ready = 1;
    tick;
    bus.ar_valid = 0;
    chk("t2_ar_ready_busy", 64'(bus.ar_ready), 64'd0);
    repeat (6) tick;
    chk("t2_beats", 64'(beats - b0), 64'd4);
    chk("t2_last_at", 64'(last_at - b0), 64'd4);
    chk("t2_ar_ready", 64'(bus.ar_ready), 64'd1);
    // 256-beat read with random backpressure
    b0 = beats;
    bus.ar_valid = 1; bus.ar_id = 9; bus.ar_len = 255;
    tick;
    bus.ar_valid = 0;
    for (int i = 0; i < 3000 && beats - b0 < 256; i++) begin
      bus.r_ready = 1'($urandom_range(0, 1));
      tick;
    end
    bus.r_ready = 1;
    repeat (2) tick;
    chk("t3_beats", 64'(beats - b0), 64'd256);
    chk("t3_last_at", 64'(last_at - b0), 64'd256);
    chk("t3_ar_ready", 64'(bus.ar_ready), 64'd1);
    // W before AW is stalled
    bus.w_valid = 1; bus.w_last = 1;
    repeat (5) tick;
    chk("t4_w_stalled", 64'(bus.w_ready), 64'd0);
    bus.aw_valid = 1; bus.aw_id = 7;
    tick;
    bus.aw_valid = 0;
    chk("t4_w_ready", 64'(bus.w_ready), 64'd1);
    tick;
    bus.w_valid = 0; bus.b_ready = 1;
    chk("t4_b_id", 64'(bus.b_id), 64'd7);
    tick;
    bus.b_ready = 0;
    // simultaneous AW and AR, B held off
    b0 = beats;
    bus.aw_valid = 1; bus.aw_id = 2; bus.ar_valid = 1; bus.ar_id = 4; bus.ar_len = 2;
    tick;
    chk("t5_aw_taken", 64'(bus.aw_ready), 64'd0);
    chk("t5_ar_taken", 64'(bus.ar_ready), 64'd0);
    bus.aw_valid = 0; bus.ar_valid = 0; bus.w_valid = 1; bus.w_last = 1;
    tick;
    bus.w_valid = 0;
    repeat (10) tick;
    chk("t5_b_held", 64'(bus.b_valid), 64'd1);
    chk("t5_r_beats", 64'(beats - b0), 64'd3);
    bus.b_ready = 1;
    tick;
    bus.b_ready = 0;
    chk("t5_b_clear", 64'(bus.b_valid), 64'd0);
    chk("t5_aw_ready", 64'(bus.aw_ready), 64'd1);
    // reset mid-read
    bus.ar_valid = 1; bus.ar_id = 6; bus.ar_len = 3;
    tick;
    bus.ar_valid = 0;
    tick;
    rst = 1;
    tick;
    chk("t6_r_valid_rst", 64'(bus.r_valid), 64'd0);
    chk("t6_ar_ready_rst", 64'(bus.ar_ready), 64'd0);
    rst = 0;
    tick;
    chk("t6_ar_ready", 64'(bus.ar_ready), 64'd1);
    b0 = beats;
    bus.ar_valid = 1; bus.ar_id = 1; bus.ar_len = 0;
    tick;
    bus.ar_valid = 0;
    repeat (3) tick;
    chk("t6_beats", 64'(beats - b0), 64'd1);
    chk("t6_rid", 64'(last_rid), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
